// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler
//   VGA timing generator plus a CPU arbiter that lends the shared
//   framebuffer/object RAM to the CPU only during vertical blanking.
//
//   Ports
//     clk_div      in   pixel clock, all state changes on its rising edge
//     reset        in   asynchronous active-high reset
//     cpu_req      in   CPU request for the shared RAM
//     cpu_done     in   CPU finished its access burst
//     h_count      out  pixel column, 0..H_TOTAL-1
//     v_count      out  line, 0..V_TOTAL-1
//     hsync/vsync  out  active-low syncs
//     video_on     out  inside the visible region
//     vblank       out  v_count >= V_VISIBLE
//     frame_start  out  one-cycle pulse at (0,0)
//     cpu_grant    out  CPU owns the shared RAM
//     preempt      out  one-cycle pulse when the window close revokes a grant
module vga_frame_scheduler #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_div,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_done,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       vblank,
  output logic       frame_start,
  output logic       cpu_grant,
  output logic       preempt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  // RAM access window spans the blanking lines except the last one,
  // which is kept quiet so the RAM is idle entering the visible region.
  localparam logic [9:0] WIN_HI   = 10'(V_TOTAL - 2);

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_RELEASE} state_t;

  state_t     r_state;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_win_cur;
  logic       w_win_nxt;

  always_comb begin
    w_h_nxt = (h_count == H_LAST) ? 10'd0 : h_count + 10'd1;
    w_v_nxt = v_count;
    if (h_count == H_LAST)
      w_v_nxt = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
  end

  // Grant uses the window as seen on the current line; revoke looks at the
  // line about to be entered so the grant drops exactly as the window closes.
  assign w_win_cur = (v_count >= V_VIS) && (v_count <= WIN_HI);
  assign w_win_nxt = (w_v_nxt >= V_VIS) && (w_v_nxt <= WIN_HI);

  // Timing outputs are decoded from the next counts so they line up with
  // the registered h_count/v_count in the same cycle.
  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      h_count     <= '0;
      v_count     <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_count     <= w_h_nxt;
      v_count     <= w_v_nxt;
      hsync       <= !((w_h_nxt >= HS_START) && (w_h_nxt < HS_END));
      vsync       <= !((w_v_nxt >= VS_START) && (w_v_nxt < VS_END));
      video_on    <= (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
      vblank      <= (w_v_nxt >= V_VIS);
      frame_start <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
    end
  end

  // Arbiter. cpu_done wins over a simultaneous window close, so a burst
  // finishing on the last open cycle is not reported as preempted.
  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      cpu_grant <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Also require the next line to be open so a request on the
          // final window cycle does not get a zero-length grant.
          if (cpu_req && w_win_cur && w_win_nxt) begin
            r_state   <= S_GRANTED;
            cpu_grant <= 1'b1;
          end
        end
        S_GRANTED: begin
          if (cpu_done) begin
            r_state   <= S_RELEASE;
            cpu_grant <= 1'b0;
          end else if (!w_win_nxt) begin
            r_state   <= S_RELEASE;
            cpu_grant <= 1'b0;
            preempt   <= 1'b1;
          end
        end
        S_RELEASE: begin
          // CPU must drop its request before it can be granted again.
          if (!cpu_req) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          cpu_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_scheduler.sv
module tb_vga_frame_scheduler;

  // Reduced timing so two whole frames stay cheap to simulate.
  //   H: 16 visible, 4 front, 6 sync, 6 back -> 32 ; hsync low at 20..25
  //   V: 12 visible, 2 front, 2 sync, 3 back -> 19 ; vsync low on 14..15
  //   access window: lines 12..17, closes entering line 18
  localparam int HT = 32;
  localparam int VT = 19;
  localparam int FRAME = HT * VT;

  logic       clk_div = 1'b0;
  logic       reset;
  logic       cpu_req;
  logic       cpu_done;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       hsync, vsync, video_on, vblank, frame_start, cpu_grant, preempt;

  vga_frame_scheduler #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut (
    .clk_div(clk_div), .reset(reset), .cpu_req(cpu_req), .cpu_done(cpu_done),
    .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .vblank(vblank), .frame_start(frame_start),
    .cpu_grant(cpu_grant), .preempt(preempt)
  );

  always #5 clk_div = ~clk_div;

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic von;
    logic vb;
    logic fs;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];
  int   hits[NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", name, act, exp, h_count, v_count);
    end
  endtask

  task automatic step();
    @(posedge clk_div);
    @(negedge clk_div);
  endtask

  task automatic goto(input int h, input int v);
    int n = 0;
    while (!(int'(h_count) == h && int'(v_count) == v) && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL goto timeout: never reached h=%0d v=%0d", h, v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " h_count"}, h_count, 0);
    chk({tag, " v_count"}, v_count, 0);
    chk({tag, " hsync"}, hsync, 1);
    chk({tag, " vsync"}, vsync, 1);
    chk({tag, " video_on"}, video_on, 0);
    chk({tag, " vblank"}, vblank, 0);
    chk({tag, " frame_start"}, frame_start, 0);
    chk({tag, " cpu_grant"}, cpu_grant, 0);
    chk({tag, " preempt"}, preempt, 0);
  endtask

  initial begin
    int mh, mv;
    int n_fs, n_hs, n_vs, n_von, n_vb;

    //            h   v  hs vs von vb fs
    tbl[0]  = '{ 0,  0, 1, 1, 1, 0, 1};
    tbl[1]  = '{ 1,  0, 1, 1, 1, 0, 0};
    tbl[2]  = '{15,  0, 1, 1, 1, 0, 0};
    tbl[3]  = '{16,  0, 1, 1, 0, 0, 0};
    tbl[4]  = '{19,  3, 1, 1, 0, 0, 0};
    tbl[5]  = '{20,  3, 0, 1, 0, 0, 0};
    tbl[6]  = '{25,  3, 0, 1, 0, 0, 0};
    tbl[7]  = '{26,  3, 1, 1, 0, 0, 0};
    tbl[8]  = '{15, 11, 1, 1, 1, 0, 0};
    tbl[9]  = '{31, 11, 1, 1, 0, 0, 0};
    tbl[10] = '{ 0, 12, 1, 1, 0, 1, 0};
    tbl[11] = '{ 5, 13, 1, 1, 0, 1, 0};
    tbl[12] = '{ 0, 14, 1, 0, 0, 1, 0};
    tbl[13] = '{22, 14, 0, 0, 0, 1, 0};
    tbl[14] = '{31, 15, 1, 0, 0, 1, 0};
    tbl[15] = '{ 0, 16, 1, 1, 0, 1, 0};
    tbl[16] = '{31, 18, 1, 1, 0, 1, 0};
    tbl[17] = '{ 0, 11, 1, 1, 1, 0, 0};
    for (int i = 0; i < NV; i++) hits[i] = 0;

    reset = 1'b1; cpu_req = 1'b0; cpu_done = 1'b0;
    step(); step();
    chk_reset_vals("reset");
    reset = 1'b0;

    // Two full frames against a counting model and the decode table.
    mh = 0; mv = 0;
    n_fs = 0; n_hs = 0; n_vs = 0; n_von = 0; n_vb = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step();
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      chk("h_count", h_count, mh);
      chk("v_count", v_count, mv);
      n_fs  += int'(frame_start);
      n_hs  += int'(!hsync);
      n_vs  += int'(!vsync);
      n_von += int'(video_on);
      n_vb  += int'(vblank);
      for (int i = 0; i < NV; i++) begin
        if (tbl[i].h == mh && tbl[i].v == mv) begin
          hits[i]++;
          chk($sformatf("vec%0d hsync", i), hsync, tbl[i].hs);
          chk($sformatf("vec%0d vsync", i), vsync, tbl[i].vs);
          chk($sformatf("vec%0d video_on", i), video_on, tbl[i].von);
          chk($sformatf("vec%0d vblank", i), vblank, tbl[i].vb);
          chk($sformatf("vec%0d frame_start", i), frame_start, tbl[i].fs);
        end
      end
    end
    for (int i = 0; i < NV; i++) chk($sformatf("vec%0d hits", i), hits[i], 2);
    chk("frame_start count", n_fs, 2);
    chk("hsync low cycles", n_hs, 2 * VT * 6);
    chk("vsync low cycles", n_vs, 2 * 2 * HT);
    chk("video_on cycles", n_von, 2 * 16 * 12);
    chk("vblank cycles", n_vb, 2 * 7 * HT);

    // Request well before the window: waits, granted one cycle after it opens.
    goto(0, 3);
    cpu_req = 1'b1;
    cpu_done = 1'b1;            // done in IDLE is ignored
    step();
    cpu_done = 1'b0;
    goto(0, 12);
    chk("early req grant@(0,12)", cpu_grant, 0);
    step();
    chk("early req grant@(1,12)", cpu_grant, 1);
    chk("early req preempt", preempt, 0);
    goto(0, 14);
    chk("grant held", cpu_grant, 1);
    cpu_done = 1'b1;
    step();
    chk("done grant drop", cpu_grant, 0);
    chk("done preempt", preempt, 0);
    cpu_done = 1'b0; cpu_req = 1'b0;
    step();

    // No cpu_done: window close revokes with one preempt pulse.
    goto(5, 15);
    cpu_req = 1'b1;
    step();
    chk("mid req grant", cpu_grant, 1);
    goto(31, 17);
    chk("pre-close grant", cpu_grant, 1);
    chk("pre-close preempt", preempt, 0);
    step();
    chk("close grant@(0,18)", cpu_grant, 0);
    chk("close preempt@(0,18)", preempt, 1);
    step();
    chk("preempt one cycle", preempt, 0);
    // Held request earns nothing in the next window until dropped.
    goto(2, 12);
    chk("held req no grant", cpu_grant, 0);
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1;
    step();
    chk("re-request grant", cpu_grant, 1);
    cpu_done = 1'b1;
    step();
    chk("re-request release", cpu_grant, 0);
    cpu_done = 1'b0; cpu_req = 1'b0;
    step();

    // cpu_done on the same edge as window close: normal completion.
    goto(5, 16);
    cpu_req = 1'b1;
    step();
    chk("tie grant", cpu_grant, 1);
    goto(31, 17);
    cpu_done = 1'b1;
    step();
    chk("tie grant drop", cpu_grant, 0);
    chk("tie preempt", preempt, 0);
    cpu_done = 1'b0; cpu_req = 1'b0;
    step();

    // Reset mid-grant: outputs forced at once, no preempt.
    goto(5, 14);
    cpu_req = 1'b1;
    step();
    chk("pre-reset grant", cpu_grant, 1);
    goto(10, 14);
    reset = 1'b1;
    #1;
    chk_reset_vals("async reset");
    @(posedge clk_div); @(negedge clk_div);
    chk_reset_vals("held reset");
    cpu_req = 1'b0;
    reset = 1'b0;
    step();
    chk("post-reset h_count", h_count, 1);
    chk("post-reset v_count", v_count, 0);
    chk("post-reset video_on", video_on, 1);
    chk("post-reset grant", cpu_grant, 0);
    chk("post-reset preempt", preempt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_scheduler.md
VGA_FRAME_SCHEDULER -- requirements
Module: vga_frame_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_VISIBLE 640 active pixels per line; H_FRONT 16 front porch; H_SYNC 96 hsync width; H_BACK 48 back porch.
  V_VISIBLE 480 active lines; V_FRONT 10 front porch; V_SYNC 2 vsync width; V_BACK 33 back porch.
  H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk_div  in  1  pixel clock; all state changes on its rising edge.
  reset  in  1  asynchronous, active-high reset.
  cpu_req  in  1  CPU request for shared framebuffer/object RAM.
  cpu_done  in  1  CPU finished its access burst.
  h_count  out  10  pixel column, 0..H_TOTAL-1.
  v_count  out  10  line, 0..V_TOTAL-1.
  hsync  out  1  horizontal sync, active low.
  vsync  out  1  vertical sync, active low.
  video_on  out  1  high inside the visible region.
  vblank  out  1  high when v_count >= V_VISIBLE.
  frame_start  out  1  one-cycle pulse at (h_count, v_count) = (0, 0).
  cpu_grant  out  1  CPU owns the shared RAM.
  preempt  out  1  one-cycle pulse when a grant is revoked by window close.

Function
REQ-003 h_count increments by 1 each cycle; from H_TOTAL-1 it wraps to 0.
REQ-004 v_count increments only on the cycle h_count wraps; from V_TOTAL-1 it wraps to 0 on that same cycle.
REQ-005 All outputs are registered and are computed from the next-count values, so each decode aligns with h_count/v_count in the same cycle.
REQ-006 Decodes:
  hsync = 0 iff H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  vsync = 0 iff V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  video_on = 1 iff h_count < H_VISIBLE and v_count < V_VISIBLE.
  vblank = 1 iff v_count >= V_VISIBLE.
REQ-007 frame_start is 1 for exactly the one cycle in which the counts are (0, 0).
REQ-008 The access window is open iff V_VISIBLE <= v_count <= V_TOTAL-2 (lines 480..523). The window closes at v_count = V_TOTAL-1 so RAM is quiescent for one line before the visible region.
REQ-009 Arbiter FSM states:
  IDLE: cpu_grant = 0. Go to GRANTED on the next edge if cpu_req = 1 and the window is open.
  GRANTED: cpu_grant = 1. Go to RELEASE on the edge where cpu_done = 1, or where the window closes (preempt).
  RELEASE: cpu_grant = 0. Go to IDLE once cpu_req = 0.
REQ-010 Grant latency: cpu_grant rises one cycle after cpu_req is sampled high with the window open.
REQ-011 If cpu_done and window close occur on the same edge, the transition is to RELEASE and preempt = 0 (the burst completed normally).
REQ-012 preempt pulses for one cycle, coincident with cpu_grant falling, only on a window-close revoke.
REQ-013 A cpu_req held high through RELEASE earns no new grant. The CPU must drop cpu_req for at least one cycle before re-requesting.
REQ-014 cpu_done sampled in IDLE or RELEASE is ignored.
REQ-015 cpu_req arriving outside the window waits in IDLE and is granted one cycle after the window opens (v_count = 480, h_count = 0).

Reset
REQ-016 While reset = 1, outputs are held at: h_count = 0, v_count = 0, hsync = 1, vsync = 1, video_on = 0, vblank = 0, frame_start = 0, cpu_grant = 0, preempt = 0; FSM = IDLE.
REQ-017 These values are forced asynchronously. They are the sole exception to REQ-005/REQ-007: no frame_start is issued for the reset frame.
REQ-018 After reset deasserts, the first rising edge yields h_count = 1, v_count = 0, video_on = 1.
REQ-019 Reset asserted mid-grant drops cpu_grant immediately without a preempt pulse.

Verification
REQ-020 Run 2 full frames from reset -> 800 cycles per line, 525 lines per frame; frame_start once per frame at (0, 0); hsync low for 96 cycles starting at h = 656; vsync low on lines 490-491.
REQ-021 Count over one frame -> video_on = 1 for exactly 307200 cycles; vblank = 1 for exactly 45 x 800 cycles.
REQ-022 cpu_req asserted at v = 100 -> cpu_grant rises at (h = 1, v = 480); cpu_done at v = 485 -> grant falls the next cycle; preempt stays 0.
REQ-023 cpu_req at v = 500 with no cpu_done -> grant falls at (0, 524) with one preempt pulse; held cpu_req earns no new grant until it is dropped and the next window opens.
REQ-024 cpu_done and window close on the same edge -> grant falls with preempt = 0.
REQ-025 Reset asserted at v = 490 while granted -> all outputs take the REQ-016 values immediately; h_count = 1 at the first edge after release.
